// File: rtl/mul_unit_pkg.sv
// Shared types for the multiply execution pipe: op encoding, tag bundle and
// the per-op operand signedness used when extending to XLEN+1 bits.
package mul_unit_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    localparam int MUL_ROB_IDX_W = 6;
    localparam int MUL_RS_IDX_W  = 4;
    localparam int MUL_PREG_W    = 6;

    typedef struct packed {
        logic [MUL_ROB_IDX_W-1:0] rob_idx;
        logic [MUL_RS_IDX_W-1:0]  rs_idx;
        logic [MUL_PREG_W-1:0]    dst_preg;
    } mul_tag_t;

    function automatic logic mul_src1_signed(input mul_op_e op);
        return op != MUL_OP_MULHU;
    endfunction

    function automatic logic mul_src2_signed(input mul_op_e op);
        return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One pipeline slot: valid bit plus payload, loaded whenever the slot advances.
// Flush wins over advance; payload is never reset.
module mul_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_advance,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_advance) begin
            r_valid <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_advance) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/mul_unit.sv
// Fully pipelined RV32M/RV64M multiply pipe with per-stage bubble-collapsing
// backpressure, global flush and ROB/RS/preg tags carried alongside the data.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int LATENCY   = 3,
    parameter int ROB_IDX_W = 6,
    parameter int RS_IDX_W  = 4,
    parameter int PREG_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [XLEN-1:0]      in_src1,
    input  logic [XLEN-1:0]      in_src2,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    input  logic [RS_IDX_W-1:0]  in_rs_idx,
    input  logic [PREG_W-1:0]    in_dst_preg,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_val,
    output logic [ROB_IDX_W-1:0] out_rob_idx,
    output logic [RS_IDX_W-1:0]  out_rs_idx,
    output logic [PREG_W-1:0]    out_dst_preg,
    output logic                 busy
);

    localparam int PROD_W = 2 * XLEN;
    localparam int PW     = 2 + ROB_IDX_W + RS_IDX_W + PREG_W + PROD_W;

    // Only the low 2*XLEN bits of the (2*XLEN+2)-bit signed product ever feed
    // a result, so the operands are sign-extended straight to 2*XLEN.
    logic              w_s1_signed;
    logic              w_s2_signed;
    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;
    logic [PW-1:0]     w_in_payload;

    assign w_s1_signed  = mul_src1_signed(mul_op_e'(in_op));
    assign w_s2_signed  = mul_src2_signed(mul_op_e'(in_op));
    assign w_a_ext      = {{XLEN{w_s1_signed & in_src1[XLEN-1]}}, in_src1};
    assign w_b_ext      = {{XLEN{w_s2_signed & in_src2[XLEN-1]}}, in_src2};
    assign w_prod       = w_a_ext * w_b_ext;
    assign w_in_payload = {in_op, in_rob_idx, in_rs_idx, in_dst_preg, w_prod};

    logic [LATENCY-1:0] w_valid;
    logic [LATENCY-1:0] w_adv;
    logic [PW-1:0]      w_data [LATENCY];

    // Advance ripples back from the consumer so a held stage only blocks
    // stages behind it that are themselves full.
    always_comb begin
        w_adv            = '0;
        w_adv[LATENCY-1] = !w_valid[LATENCY-1] || out_ready;
        for (int k = LATENCY - 2; k >= 0; k--) begin
            w_adv[k] = !w_valid[k] || w_adv[k+1];
        end
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic          w_v_in;
        logic [PW-1:0] w_d_in;
        if (k == 0) begin : g_first
            assign w_v_in = in_valid;
            assign w_d_in = w_in_payload;
        end else begin : g_rest
            assign w_v_in = w_valid[k-1];
            assign w_d_in = w_data[k-1];
        end
        mul_pipe_stage #(.W(PW)) u_stage (
            .clk       (clk),
            .rst_n     (rst),
            .i_advance (w_adv[k]),
            .i_flush   (flush),
            .i_valid   (w_v_in),
            .i_data    (w_d_in),
            .o_valid   (w_valid[k]),
            .o_data    (w_data[k])
        );
    end

    logic [PW-1:0]     w_out;
    logic [PROD_W-1:0] w_out_prod;
    mul_op_e           w_out_op;

    assign w_out      = w_data[LATENCY-1];
    assign w_out_prod = w_out[PROD_W-1:0];
    assign w_out_op   = mul_op_e'(w_out[PW-1 -: 2]);

    assign out_val      = (w_out_op == MUL_OP_MUL) ? w_out_prod[XLEN-1:0]
                                                   : w_out_prod[PROD_W-1:XLEN];
    assign out_dst_preg = w_out[PROD_W +: PREG_W];
    assign out_rs_idx   = w_out[PROD_W + PREG_W +: RS_IDX_W];
    assign out_rob_idx  = w_out[PROD_W + PREG_W + RS_IDX_W +: ROB_IDX_W];
    assign out_valid    = w_valid[LATENCY-1];
    assign in_ready     = w_adv[0];
    assign busy         = |w_valid;

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
Parametrised, fully pipelined RV32M/RV64M multiply execution pipe. It replaces the fixed 3-stage multiplier pipe in the backend execute stage.
- Accepts one uop per cycle and implements MUL/MULH/MULHSU/MULHU result selection internally.
- Carries ROB, RS and destination tags alongside the data.
- Supports per-stage bubble-collapsing backpressure and a global flush.
- Output feeds one writeback/bypass pipe, one ROB state-update pipe and one scheduler free port.

Parameters:
XLEN, 32, operand/result width (32 or 64)
LATENCY, 3, register stages from accept to out_valid (>=1)
ROB_IDX_W, 6, ROB index width
RS_IDX_W, 4, scheduler entry index width
PREG_W, 6, physical register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (low = reset)
in_valid  in  1  uop offered
in_ready  out  1  uop accepted when in_valid && in_ready
in_op  in  2  mul_op_e (see package)
in_src1  in  XLEN  rs1 value
in_src2  in  XLEN  rs2 value
in_rob_idx  in  ROB_IDX_W  ROB entry
in_rs_idx  in  RS_IDX_W  scheduler entry
in_dst_preg  in  PREG_W  destination physical reg
flush  in  1  kill all in-flight and same-cycle input
out_valid  out  1  result present
out_ready  in  1  consumer takes result when out_valid && out_ready
out_val  out  XLEN  selected result
out_rob_idx  out  ROB_IDX_W  tag of result
out_rs_idx  out  RS_IDX_W  tag of result
out_dst_preg  out  PREG_W  tag of result
busy  out  1  any stage valid

Behaviour:
- Reset (rst low, async): all stage valid bits clear. out_valid=0 and busy=0 immediately. in_ready=1 after reset. Data/tag regs need no reset; out_val/tags are don't-care while out_valid=0.
- Pipeline: LATENCY stages S0..S(L-1), each holding valid, op, tags and the partial/full product. out_* are driven from S(L-1).
- Advance rules:
  - S(L-1) advances if !valid or out_ready.
  - Sk advances if !Sk.valid or S(k+1) advances.
  - in_ready = S0 advances. This is combinational from out_ready, with no registered path.
  - A stage that does not advance holds its contents. A stage that advances with no incoming valid becomes a bubble, so bubbles collapse.
- Latency: with out_ready held high, a uop accepted in cycle t gives out_valid in cycle t+LATENCY. Throughput is 1 per cycle. Results emerge in acceptance order.
- Arithmetic: extend each operand to XLEN+1 bits by sign or zero, then form a signed (2XLEN+2)-bit product.
  - MUL: signed/signed, result = product[XLEN-1:0].
  - MULH: signed/signed, result = product[2XLEN-1:XLEN].
  - MULHSU: rs1 signed, rs2 unsigned, result = product[2XLEN-1:XLEN].
  - MULHU: unsigned/unsigned, result = product[2XLEN-1:XLEN].
  - The product is computed from S0 inputs and may be retimed across stages. Result select happens at S(L-1) using the carried op.
- Flush: every stage valid clears at the next edge. Input in the flush cycle is dropped (in_ready may be high; the uop is not accepted). out_valid in the flush cycle is still visible, but the consumer must ignore it.
- Simultaneous flush with out_valid && out_ready: the result is considered dropped, not delivered.
- Reset mid-operation: all in-flight uops are lost and no output is produced for them.
- LATENCY=1: S0 is the output stage, and in_ready = !out_valid || out_ready.
- No overflow exceptions. MUL never traps.

Decomposition:
- CORE_PKG additions:
  - mul_op_e enum, 2 bits: MUL_OP_MUL=2'b00, MUL_OP_MULH=2'b01, MUL_OP_MULHSU=2'b10, MUL_OP_MULHU=2'b11. These match the funct3[1:0] encoding.
  - A mul_tag_t struct holding the rob/rs/preg indices.
- Sub-module mul_pipe_stage holds one valid+payload register with advance logic. It is instantiated LATENCY times in a generate loop.
- Operand extension and result select stay inline in mul_unit.

Test Plan:
- XLEN=32, LATENCY=3, out_ready=1, MUL 7 x 0xFFFFFFFD -> out_val 0xFFFFFFEB exactly 3 cycles later, with tags echoed.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHSU 0x00000002 x 0x80000000 -> 0x00000001.
- Stream 6 back-to-back uops (rob 0..5) and hold out_ready=0 for 4 cycles from the first out_valid -> in_ready falls once 3 uops are held. All 6 results emerge in order 0..5 with no duplication or loss.
- Issue a uop, stall 1 cycle, issue another; drop out_ready for 1 cycle -> the bubble collapses and the two results appear on consecutive cycles after out_ready rises.
- 2 uops in flight, flush=1 with in_valid=1 -> no out_valid for any of the 3 uops, and busy=0 the next cycle.
- Assert rst low mid-stream, asynchronously between edges -> out_valid and busy drop immediately. After release, a new MUL 3 x 4 -> 12 at latency 3.
